// File: rtl/axi_ar_arbiter_pkg.sv
// Shared AXI read-address arbitration definitions: default channel widths, AR/AW state
// encoding and the round-robin pointer advance helper.
package axi_ar_arbiter_pkg;

  localparam int unsigned AXI_ID_WIDTH   = 4;
  localparam int unsigned AXI_ADDR_WIDTH = 16;

  // Output-register state; ST_SEND means a request is being presented downstream.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Priority moves to the master just after the winner, wrapping at n-1.
  function automatic int unsigned rr_next(input int unsigned w, input int unsigned n);
    return (w == n - 1) ? 0 : w + 1;
  endfunction

endpackage

// File: rtl/axi_ar_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: scans requests starting at i_ptr and returns the
// first active one as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [IDX_W:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // Position modulo NUM_REQ; one extra bit avoids overflow before the wrap.
      w_pos = {1'b0, i_ptr} + (IDX_W + 1)'(k);
      if (w_pos >= (IDX_W + 1)'(NUM_REQ)) begin
        w_pos = w_pos - (IDX_W + 1)'(NUM_REQ);
      end
      if (!o_valid && i_req[w_pos[IDX_W-1:0]]) begin
        o_grant[w_pos[IDX_W-1:0]] = 1'b1;
        o_idx                     = w_pos[IDX_W-1:0];
        o_valid                   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_ar_arbiter.sv
// Shares one AXI AR channel among NUM_MST masters with round-robin arbitration and a
// registered output; the winner index is prepended to ARID for R-channel routing.
module axi_ar_arbiter
  import axi_ar_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MST = 4,
  parameter int unsigned ID_W    = AXI_ID_WIDTH,
  parameter int unsigned ADDR_W  = AXI_ADDR_WIDTH,
  localparam int unsigned IDX_W  = $clog2(NUM_MST)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MST*ID_W-1:0]   s_arid,
  input  logic [NUM_MST*ADDR_W-1:0] s_araddr,
  input  logic [NUM_MST-1:0]        s_arvalid,
  output logic [NUM_MST-1:0]        s_arready,
  output logic [IDX_W+ID_W-1:0]     m_arid,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [IDX_W-1:0]          m_grant_idx
);

  logic [0:0]            r_state;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [IDX_W+ID_W-1:0] r_arid;
  logic [ADDR_W-1:0]     r_araddr;
  logic [IDX_W-1:0]      r_grant_idx;

  logic [NUM_MST-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_accept;

  rr_arbiter #(
    .NUM_REQ (NUM_MST)
  ) u_rr_arbiter (
    .i_req   (s_arvalid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  // Register is free when empty or being drained this cycle (same-cycle refill).
  assign w_accept  = (r_state == ST_IDLE) || ((r_state == ST_SEND) && m_arready);
  assign s_arready = (w_accept && !rst) ? w_grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_arid      <= '0;
      r_araddr    <= '0;
      r_grant_idx <= '0;
    end else if (w_accept && w_any) begin
      r_state     <= ST_SEND;
      r_rr_ptr    <= IDX_W'(rr_next(32'(w_idx), NUM_MST));
      r_arid      <= {w_idx, s_arid[w_idx*ID_W +: ID_W]};
      r_araddr    <= s_araddr[w_idx*ADDR_W +: ADDR_W];
      r_grant_idx <= w_idx;
    end else if ((r_state == ST_SEND) && m_arready) begin
      r_state <= ST_IDLE;
    end
  end

  assign m_arvalid   = (r_state == ST_SEND);
  assign m_arid      = r_arid;
  assign m_araddr    = r_araddr;
  assign m_grant_idx = r_grant_idx;

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Randomised and directed bench for axi_ar_arbiter with a queue-based scoreboard and a
// behavioural round-robin model.
module tb_axi_ar_arbiter;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int AW = 16;
  localparam int XW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*IW-1:0] s_arid;
  logic [N*AW-1:0] s_araddr;
  logic [N-1:0]    s_arvalid;
  logic [N-1:0]    s_arready;
  logic [XW+IW-1:0] m_arid;
  logic [AW-1:0]   m_araddr;
  logic            m_arvalid;
  logic            m_arready;
  logic [XW-1:0]   m_grant_idx;

  axi_ar_arbiter #(
    .NUM_MST (N),
    .ID_W    (IW),
    .ADDR_W  (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_arid      (s_arid),
    .s_araddr    (s_araddr),
    .s_arvalid   (s_arvalid),
    .s_arready   (s_arready),
    .m_arid      (m_arid),
    .m_araddr    (m_araddr),
    .m_arvalid   (m_arvalid),
    .m_arready   (m_arready),
    .m_grant_idx (m_grant_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XW+IW-1:0] id;
    logic [AW-1:0]    addr;
    logic [XW-1:0]    idx;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_ptr = 0;
  bit   m_busy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One stimulus cycle: drive at negedge, check s_arready against the model, update model.
  task automatic cycle(input bit r, input logic [N-1:0] v, input bit rdy, input bit fix = 1'b0);
    logic [N-1:0] er;
    int w;
    @(negedge clk);
    rst       = r;
    s_arvalid = v;
    m_arready = rdy;
    for (int i = 0; i < N; i++) begin
      s_arid[i*IW +: IW]   = fix ? IW'(4'h5) : IW'($urandom);
      s_araddr[i*AW +: AW] = fix ? AW'(16'h0010) : AW'($urandom);
    end
    #1;
    chk("m_arvalid_state", m_arvalid, m_busy);
    er = '0;
    w  = -1;
    if (!r && (!m_busy || rdy)) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (w < 0 && v[j]) w = j;
      end
    end
    if (w >= 0) er[w] = 1'b1;
    chk("s_arready", s_arready, er);
    if (r) begin
      m_ptr  = 0;
      m_busy = 1'b0;
      q.delete();
    end else if (w >= 0) begin
      exp_t e;
      e.id   = {XW'(w), s_arid[w*IW +: IW]};
      e.addr = s_araddr[w*AW +: AW];
      e.idx  = XW'(w);
      q.push_back(e);
      m_ptr  = (w + 1) % N;
      m_busy = 1'b1;
    end else if (m_busy && rdy) begin
      m_busy = 1'b0;
    end
  endtask

  // Monitor: stability, s_arready legality, and scoreboard pop on each slave handshake.
  initial begin
    bit               hold;
    logic [XW+IW-1:0] p_id;
    logic [AW-1:0]    p_addr;
    hold = 1'b0;
    p_id = '0;
    p_addr = '0;
    forever begin
      @(negedge clk);
      #2;
      chk("s_arready_onehot0", {63'd0, $onehot0(s_arready)}, 64'd1);
      chk("s_arready_no_valid", {60'd0, s_arready & ~s_arvalid}, 64'd0);
      if (rst) begin
        hold = 1'b0;
        chk("rst_s_arready", {60'd0, s_arready}, 64'd0);
      end else begin
        if (hold) begin
          chk("stable_valid", {63'd0, m_arvalid}, 64'd1);
          chk("stable_id", {58'd0, m_arid}, {58'd0, p_id});
          chk("stable_addr", {48'd0, m_araddr}, {48'd0, p_addr});
        end
        if (m_arvalid && m_arready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got handshake id=%0h expected none", m_arid);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_arid", {58'd0, m_arid}, {58'd0, e.id});
            chk("sb_araddr", {48'd0, m_araddr}, {48'd0, e.addr});
            chk("sb_grant_idx", {62'd0, m_grant_idx}, {62'd0, e.idx});
          end
        end
        hold   = m_arvalid && !m_arready;
        p_id   = m_arid;
        p_addr = m_araddr;
      end
    end
  end

  initial begin
    rst       = 1'b1;
    s_arvalid = '0;
    s_arid    = '0;
    s_araddr  = '0;
    m_arready = 1'b0;

    // Reset held with every master requesting
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'hF, 1'b1);
      chk("rst_m_arid", {58'd0, m_arid}, 64'd0);
      chk("rst_m_araddr", {48'd0, m_araddr}, 64'd0);
      chk("rst_grant_idx", {62'd0, m_grant_idx}, 64'd0);
    end

    // Single master 2 with fixed id/addr
    cycle(1'b0, 4'b0100, 1'b1, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    chk("single_arid", {58'd0, m_arid}, {58'd0, 6'h25});
    chk("single_araddr", {48'd0, m_araddr}, 64'h10);
    cycle(1'b0, 4'b0000, 1'b1);

    // All masters continuously valid
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'hF, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);

    // Backpressure then release
    cycle(1'b0, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'hF, 1'b0);
    cycle(1'b0, 4'hF, 1'b1);
    cycle(1'b0, 4'hF, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);

    // Priority wrap after granting master 3
    cycle(1'b0, 4'b1000, 1'b1);
    cycle(1'b0, 4'b1001, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    chk("wrap_grant_idx", {62'd0, m_grant_idx}, 64'd0);
    cycle(1'b0, 4'h0, 1'b1);

    // Reset while a request is stalled
    cycle(1'b0, 4'b0100, 1'b0);
    cycle(1'b0, 4'b0110, 1'b0);
    cycle(1'b1, 4'b0110, 1'b0);
    cycle(1'b0, 4'b0110, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    chk("post_rst_grant_idx", {62'd0, m_grant_idx}, 64'd1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 59) == 0), N'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Drain
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 1'b1);
    @(negedge clk);
    #3;
    chk("sb_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
